// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared FSM encoding, default frame parameters and width helpers for the UART blocks
package axis_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLOCK_DIV  = 4;
    localparam int DEF_STOP_BITS  = 1;
    localparam int FRAME_BITS     = 1 + DEF_DATA_WIDTH + DEF_STOP_BITS;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A counter still needs one bit when it only ever holds zero.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: divides the clock into UART bit periods of CLOCK_DIV cycles
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset, clears the divider
//   restart    : holds the divider at zero so the next bit starts on a clean boundary
//   tick       : high during the final cycle of each bit
//   last_cycle : high one cycle before tick, so a caller can register an output
//                that must already be valid during the bit's final cycle
module uart_bit_timer
    import axis_uart_pkg::*;
#(
    parameter int CLOCK_DIV = DEF_CLOCK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick,
    output logic last_cycle
);

    localparam int CW = cnt_width(CLOCK_DIV);

    logic [CW-1:0] cnt;

    assign tick       = cnt == CW'(CLOCK_DIV - 1);
    assign last_cycle = cnt == CW'(CLOCK_DIV - 2);

    always_ff @(posedge clock) begin
        if (reset || restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI-stream word consumer that serialises each word onto a UART line, LSB first
//   clock  : system clock, rising edge
//   reset  : synchronous active-high reset; abandons any frame in progress
//   idata  : stream data, latched only on handshake
//   ivalid : stream valid
//   iready : stream ready (registered); high in IDLE and in the final stop cycle
//   txd    : UART line (registered), idles high
//   busy   : high while a frame is in progress (registered)
module axis_uart_tx
    import axis_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLOCK_DIV  = DEF_CLOCK_DIV,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  ivalid,
    output logic                  iready,
    output logic                  txd,
    output logic                  busy
);

    localparam int BW = cnt_width(DATA_WIDTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  tick;
    logic                  last_cycle;
    logic                  take;
    logic                  final_stop;

    assign take       = ivalid && iready;
    assign final_stop = stop_cnt == 1'(STOP_BITS - 1);

    // The divider is parked at zero in IDLE, so a frame's first bit is always full length.
    uart_bit_timer #(
        .CLOCK_DIV(CLOCK_DIV)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .restart   (state == IDLE),
        .tick      (tick),
        .last_cycle(last_cycle)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
            iready   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    iready <= !take;
                    busy   <= take;
                    txd    <= !take;
                    if (take) begin
                        shift <= idata;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        txd     <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            state    <= STOP;
                            txd      <= 1'b1;
                            stop_cnt <= 1'b0;
                        end else begin
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                STOP: begin
                    // Open the stream for the last stop cycle so a waiting word starts with no gap.
                    if (last_cycle && final_stop)
                        iready <= 1'b1;
                    if (tick) begin
                        if (!final_stop) begin
                            stop_cnt <= 1'b1;
                        end else if (take) begin
                            shift  <= idata;
                            state  <= START;
                            txd    <= 1'b0;
                            iready <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: randomized self-checking bench for axis_uart_tx against a per-cycle line model
module tb_axis_uart_tx;

    logic       clock;
    logic       reset;
    logic [7:0] idata;
    logic       ivalid;
    logic       iready;
    logic       txd;
    logic       busy;
    logic [6:0] idata2;
    logic       ivalid2;
    logic       iready2;
    logic       txd2;
    logic       busy2;

    int n_cmp;
    int n_fail;

    axis_uart_tx dut (
        .clock (clock),
        .reset (reset),
        .idata (idata),
        .ivalid(ivalid),
        .iready(iready),
        .txd   (txd),
        .busy  (busy)
    );

    axis_uart_tx #(
        .DATA_WIDTH(7),
        .CLOCK_DIV (2),
        .STOP_BITS (2)
    ) dut2 (
        .clock (clock),
        .reset (reset),
        .idata (idata2),
        .ivalid(ivalid2),
        .iready(iready2),
        .txd   (txd2),
        .busy  (busy2)
    );

    always #5 clock = ~clock;

    // Expected line level k cycles into a frame: start bit, data LSB first, then stop bits.
    function automatic logic line_bit(input logic [7:0] d, input int dw, input int div, input int k);
        int idx;
        idx = k / div;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return d[idx-1];
        return 1'b1;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 100 && iready !== 1'b1; i++) step;
        n_cmp++;
        if (iready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready: iready=%b required 1", iready);
        end
    endtask

    // Sends one word and checks every cycle of its frame; noise wiggles the stream mid-frame.
    task automatic do_frame(input logic [7:0] d, input bit noise);
        wait_ready();
        idata  = d;
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        idata  = 8'($urandom);
        for (int k = 1; k <= 40; k++) begin
            n_cmp += 3;
            if (txd !== line_bit(d, 8, 4, k - 1)) begin
                n_fail++;
                $display("FAIL frame_txd d=%h cycle %0d: txd=%b required %b", d, k, txd, line_bit(d, 8, 4, k - 1));
            end
            if (iready !== (k == 40)) begin
                n_fail++;
                $display("FAIL frame_iready d=%h cycle %0d: iready=%b required %b", d, k, iready, k == 40);
            end
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_busy d=%h cycle %0d: busy=%b required 1", d, k, busy);
            end
            if (noise && k < 40) begin
                ivalid = 1'($urandom);
                idata  = 8'($urandom);
            end else begin
                ivalid = 1'b0;
            end
            step();
        end
        n_cmp += 3;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end_busy d=%h: busy=%b required 0", d, busy);
        end
        if (iready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_end_iready d=%h: iready=%b required 1", d, iready);
        end
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_end_txd d=%h: txd=%b required 1", d, txd);
        end
    endtask

    task automatic test_reset;
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp += 4;
            if (txd !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_txd: txd=%b required 1", txd);
            end
            if (iready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_iready: iready=%b required 0", iready);
            end
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy: busy=%b required 0", busy);
            end
            if ({txd2, iready2, busy2} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_dut2: txd/iready/busy=%b required 100", {txd2, iready2, busy2});
            end
            idata = 8'($urandom);
            step();
        end
        reset = 1'b0;
        step();
        n_cmp += 3;
        if (iready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_iready: iready=%b required 1", iready);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_busy: busy=%b required 0", busy);
        end
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL release_txd: txd=%b required 1", txd);
        end
        ivalid = 1'b0;
        step();
    endtask

    task automatic test_stall;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({txd, busy, iready} !== 3'b101) begin
                n_fail++;
                $display("FAIL stall: txd/busy/iready=%b required 101", {txd, busy, iready});
            end
            idata = 8'($urandom);
            step();
        end
    endtask

    task automatic test_frame;
        do_frame(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) do_frame(8'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back;
        logic       s [80];
        logic [7:0] dec0;
        logic [7:0] dec1;
        int         bad;
        wait_ready();
        idata  = 8'h00;
        ivalid = 1'b1;
        step();
        idata = 8'hFF;
        for (int k = 1; k <= 80; k++) begin
            s[k-1] = txd;
            n_cmp += 2;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy cycle %0d: busy=%b required 1", k, busy);
            end
            if (iready !== (k == 40 || k == 80)) begin
                n_fail++;
                $display("FAIL b2b_iready cycle %0d: iready=%b required %b", k, iready, k == 40 || k == 80);
            end
            if (k == 41) ivalid = 1'b0;
            step();
        end
        bad = 0;
        for (int k = 0; k < 80; k++)
            if (s[k] !== (k < 40 ? line_bit(8'h00, 8, 4, k) : line_bit(8'hFF, 8, 4, k - 40))) bad++;
        for (int i = 0; i < 8; i++) begin
            dec0[i] = s[(1 + i) * 4 + 2];
            dec1[i] = s[40 + (1 + i) * 4 + 2];
        end
        n_cmp += 5;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_line: %0d cycles differ, required 0", bad);
        end
        if (s[40] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_start: txd=%b required 0", s[40]);
        end
        if (dec0 !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_decode0: got %h required 00", dec0);
        end
        if (dec1 !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_decode1: got %h required ff", dec1);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_noise;
        for (int i = 0; i < 3; i++) do_frame(8'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({txd, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL noise_idle: txd/busy=%b required 10", {txd, busy});
            end
            step();
        end
    endtask

    task automatic test_reset_mid;
        wait_ready();
        idata  = 8'h5A;
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            n_cmp++;
            if (txd !== line_bit(8'h5A, 8, 4, k - 1)) begin
                n_fail++;
                $display("FAIL mid_txd cycle %0d: txd=%b required %b", k, txd, line_bit(8'h5A, 8, 4, k - 1));
            end
            if (k == 18) reset = 1'b1;
            step();
        end
        n_cmp += 3;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_txd: txd=%b required 1", txd);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_busy: busy=%b required 0", busy);
        end
        if (iready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_iready: iready=%b required 0", iready);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (iready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release_iready: iready=%b required 1", iready);
        end
        do_frame(8'h3C, 1'b0);
    endtask

    task automatic test_narrow;
        for (int i = 0; i < 100 && iready2 !== 1'b1; i++) step();
        idata2  = 7'h41;
        ivalid2 = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            logic e;
            e = (k <= 20) ? line_bit(8'h41, 7, 2, k - 1) : line_bit(8'h41, 7, 2, k - 21);
            n_cmp += 3;
            if (txd2 !== e) begin
                n_fail++;
                $display("FAIL narrow_txd cycle %0d: txd=%b required %b", k, txd2, e);
            end
            if (iready2 !== (k == 20 || k == 40)) begin
                n_fail++;
                $display("FAIL narrow_iready cycle %0d: iready=%b required %b", k, iready2, k == 20 || k == 40);
            end
            if (busy2 !== 1'b1) begin
                n_fail++;
                $display("FAIL narrow_busy cycle %0d: busy=%b required 1", k, busy2);
            end
            if (k == 21) ivalid2 = 1'b0;
            step();
        end
        n_cmp++;
        if (busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL narrow_end_busy: busy=%b required 0", busy2);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        clock   = 1'b0;
        reset   = 1'b1;
        ivalid  = 1'b1;
        idata   = 8'($urandom);
        ivalid2 = 1'b0;
        idata2  = 7'h00;
        test_reset();
        test_stall();
        test_frame();
        test_back_to_back();
        test_noise();
        test_reset_mid();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
